ahb_slave_if: RTL and testbench
===============================

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 Parameter SRAM_AW, default 14, SHALL set the SRAM word-address width; haddr[SRAM_AW+1:2] maps to sram_Addr.
REQ-002 hclk  input  1  SHALL be the single clock; the SRAM array runs on this same clock.
REQ-003 hresetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 hsel, hready  input  1 each  SHALL be the AHB-Lite slave select and the bus-ready input.
REQ-005 htrans[1:0], hsize[2:0], hwrite, haddr[31:0], hwdata[31:0]  input  SHALL be the AHB-Lite transfer controls, address and write data.
REQ-006 hready_out  output  1, hresp[1:0]  output  2, hrdata[31:0]  output  32  SHALL be the slave response signals.
REQ-007 sram_wen  output  1  SHALL be the active-low write enable, where 0 means write.
REQ-008 sram_ByteEna  output  4  SHALL be the active-low per-byte chip select, where 1111 means idle.
REQ-009 sram_Addr  output  SRAM_AW, and sram_Wdata  output  32,  SHALL carry the SRAM address and write data.
REQ-010 sram_Rdata  input  32  SHALL carry the SRAM read data, valid the cycle after a read access.

Function
REQ-011 A transfer SHALL be accepted when hsel=1, htrans is NONSEQ(10) or SEQ(11), and hready=1; IDLE and BUSY transfers SHALL receive a zero-wait OKAY.
REQ-012 The byte mask SHALL follow hsize and haddr[1:0]:
- byte: enable lane haddr[1:0];
- half: enable lanes 0-1 if haddr[1]=0, else lanes 2-3;
- word: enable all four lanes.
REQ-013 An accepted transfer with hsize>2, a half at haddr[0]=1, or a word at haddr[1:0]!=0 SHALL get a two-cycle ERROR response and SHALL NOT access the SRAM:
- cycle 1: hresp=01, hready_out=0;
- cycle 2: hresp=01, hready_out=1.
REQ-014 The FSM SHALL have the states IDLE, WR_DATA, RD_DATA, WR_STALL, ERR1 and ERR2.
REQ-015 On an accepted write, the FSM SHALL register the address and byte mask, then in the next cycle (WR_DATA) drive sram_wen=0, sram_ByteEna=~mask, sram_Addr=registered address and sram_Wdata=hwdata, with hready_out=1.
REQ-016 An accepted read SHALL drive sram_wen=1, sram_ByteEna=0000 and sram_Addr from haddr combinationally in its address phase; in RD_DATA, hrdata SHALL equal sram_Rdata with hready_out=1 (zero wait states).
REQ-017 A read presented during WR_DATA SHALL stall for one cycle:
- cycle N: perform the write and drive hready_out=0 (WR_STALL);
- cycle N+1: issue the read from the held haddr with hready_out=1;
- cycle N+2: RD_DATA, read data returned.
REQ-018 A write presented during WR_DATA SHALL be pipelined back-to-back with no wait state.
REQ-019 Whenever no SRAM access is scheduled, sram_ByteEna SHALL be 1111 and sram_wen SHALL be 1.
REQ-020 hresp SHALL be 00 (OKAY) except in ERR1 and ERR2.
REQ-021 hrdata SHALL be 0 outside RD_DATA.
REQ-022 Address bits above SRAM_AW+1 SHALL be ignored, so the address wraps modulo 2^(SRAM_AW+2) bytes.

Reset
REQ-023 While hresetn=0, the block SHALL hold:
- state IDLE;
- hready_out=1, hresp=00, hrdata=0;
- sram_wen=1, sram_ByteEna=1111;
- sram_Addr=0, sram_Wdata=0;
- all registered controls cleared.
REQ-024 Asserting hresetn mid-transfer SHALL abort the transfer immediately, and no SRAM write SHALL occur in any cycle where hresetn=0.

Verification
REQ-025 Word write then read: write 0xDEADBEEF at 0x0000_0100, then read 0x100 -> sram_Addr=0x040, ByteEna=0000 on the write, hrdata=0xDEADBEEF, exactly one wait state on the read.
REQ-026 Byte writes: write 0x11, 0x22, 0x33, 0x44 at 0x200-0x203, then a word read -> ByteEna 1110, 1101, 1011, 0111 in turn; hrdata=0x44332211.
REQ-027 Halfword and bank test: half write 0xABCD at 0x8002, then read 0x8000 -> ByteEna=0011, sram_Addr[13]=1, hrdata[31:16]=0xABCD.
REQ-028 Error response: word access at 0x101 -> hresp=01 for two cycles with hready_out 0 then 1; ByteEna stays 1111 throughout.
REQ-029 Back-to-back streams: four SEQ writes followed by four SEQ reads -> no wait states within the write or read bursts, one stall at the write-to-read turnaround, all data matches.
REQ-030 Reset during write: drop hresetn in a WR_DATA cycle -> sram_wen=1 in that cycle, and a later read of that location returns its prior contents.

Source files
------------

// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------------------------
// ahb_slave_if
//   AHB-Lite slave front end for a single-port synchronous SRAM clocked by hclk.
//   Reads are issued to the SRAM in their address phase, so read data returns with zero wait
//   states. Writes are registered and performed in the data phase, when hwdata is valid. A
//   read arriving while a write occupies the SRAM costs one wait state. Misaligned or
//   oversized transfers get a two-cycle ERROR response and never touch the SRAM.
//
// Ports
//   hclk, hresetn      : clock and asynchronous active-low reset
//   hsel, hready       : slave select, bus ready input
//   htrans, hsize,
//   hwrite, haddr,
//   hwdata             : AHB-Lite transfer controls, address and write data
//   hready_out, hresp,
//   hrdata             : slave response
//   sram_wen           : SRAM write enable, active low
//   sram_ByteEna       : SRAM per-byte chip select, active low (4'b1111 = idle)
//   sram_Addr          : SRAM word address (haddr[SRAM_AW+1:2])
//   sram_Wdata         : SRAM write data
//   sram_Rdata         : SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------------------------
module ahb_slave_if #(
    parameter int unsigned SRAM_AW = 14
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hsel,
    input  logic               hready,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic               hwrite,
    input  logic [31:0]        haddr,
    input  logic [31:0]        hwdata,
    output logic               hready_out,
    output logic [1:0]         hresp,
    output logic [31:0]        hrdata,
    output logic               sram_wen,
    output logic [3:0]         sram_ByteEna,
    output logic [SRAM_AW-1:0] sram_Addr,
    output logic [31:0]        sram_Wdata,
    input  logic [31:0]        sram_Rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StRdData,
        StWrStall,
        StErr1,
        StErr2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRAM_AW-1:0] r_addr;
    logic [SRAM_AW-1:0] w_addr_nxt;
    logic [3:0]         r_mask;
    logic [3:0]         w_mask_nxt;

    logic               w_active;
    logic               w_accept;
    logic               w_err;
    logic               w_stall;
    logic [3:0]         w_mask;
    logic [SRAM_AW-1:0] w_word_addr;
    logic               w_unused;

    // Upper address bits are ignored so the address space wraps; htrans[0] (SEQ vs NONSEQ)
    // does not change the behaviour.
    assign w_unused    = ^{haddr[31:SRAM_AW+2], htrans[0]};

    assign w_word_addr = haddr[SRAM_AW+1:2];
    assign w_active    = hsel & htrans[1];
    assign w_accept    = w_active & hready;

    // Byte-lane mask and alignment check for the transfer in its address phase.
    always_comb begin
        w_mask = 4'b0000;
        w_err  = 1'b0;
        case (hsize)
            3'd0: w_mask = 4'b0001 << haddr[1:0];
            3'd1: begin
                w_mask = haddr[1] ? 4'b1100 : 4'b0011;
                w_err  = haddr[0];
            end
            3'd2: begin
                w_mask = 4'b1111;
                w_err  = |haddr[1:0];
            end
            default: w_err = 1'b1;
        endcase
    end

    // The SRAM is busy writing during WR_DATA, so a valid read presented then must wait. This
    // ignores hready on purpose: hready_out feeds hready in a single-slave system.
    assign w_stall = (r_state == StWrData) & w_active & ~hwrite & ~w_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_mask_nxt   = r_mask;
        hready_out   = 1'b1;
        hresp        = 2'b00;
        hrdata       = 32'h0;
        sram_wen     = 1'b1;
        sram_ByteEna = 4'b1111;
        sram_Addr    = '0;
        sram_Wdata   = 32'h0;

        // Data-phase behaviour of the current state.
        unique case (r_state)
            StErr1: begin
                hready_out  = 1'b0;
                hresp       = 2'b01;
                w_state_nxt = StErr2;
            end
            StErr2:   hresp = 2'b01;
            StRdData: hrdata = sram_Rdata;
            StWrData: begin
                sram_wen     = 1'b0;
                sram_ByteEna = ~r_mask;
                sram_Addr    = r_addr;
                sram_Wdata   = hwdata;
            end
            default: ;
        endcase

        // Address-phase decode of the next transfer (not in ERR1, where the bus is held).
        if (w_stall) begin
            hready_out  = 1'b0;
            w_state_nxt = StWrStall;
        end else if (r_state != StErr1) begin
            if (w_accept) begin
                if (w_err) begin
                    w_state_nxt = StErr1;
                end else if (hwrite) begin
                    w_state_nxt = StWrData;
                    w_addr_nxt  = w_word_addr;
                    w_mask_nxt  = w_mask;
                end else begin
                    // Read goes to the SRAM now so data is ready in RD_DATA.
                    w_state_nxt  = StRdData;
                    sram_ByteEna = 4'b0000;
                    sram_Addr    = w_word_addr;
                end
            end else begin
                w_state_nxt = StIdle;
            end
        end

        // Reset aborts immediately: no SRAM access and idle response while hresetn is low.
        if (!hresetn) begin
            hready_out   = 1'b1;
            hresp        = 2'b00;
            hrdata       = 32'h0;
            sram_wen     = 1'b1;
            sram_ByteEna = 4'b1111;
            sram_Addr    = '0;
            sram_Wdata   = 32'h0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
`timescale 1ns/1ps
module tb_ahb_slave_if;

    localparam int unsigned AW     = 14;
    localparam int unsigned NWORDS = 1 << AW;
    localparam int unsigned RBASE  = 32'h1000;  // word region used by the random test
    localparam int unsigned RSPAN  = 16;

    logic          hclk;
    logic          hresetn;
    logic          hsel;
    logic          hready;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [31:0]   haddr;
    logic [31:0]   hwdata;
    logic          hready_out;
    logic [1:0]    hresp;
    logic [31:0]   hrdata;
    logic          sram_wen;
    logic [3:0]    sram_ByteEna;
    logic [AW-1:0] sram_Addr;
    logic [31:0]   sram_Wdata;
    logic [31:0]   sram_Rdata;
    logic          mem_init;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic          rdy;
        logic [1:0]    resp;
        logic [31:0]   rdata;
        logic          wen;
        logic [3:0]    be;
        logic [AW-1:0] sa;
        logic [31:0]   wd;
    } cyc_t;

    xfer_t       xq[$];
    cyc_t        clog[$];
    int          obs_wait[$];
    logic [1:0]  obs_resp[$];
    logic [31:0] obs_rdata[$];

    ahb_slave_if #(.SRAM_AW(AW)) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hsel         (hsel),
        .hready       (hready),
        .htrans       (htrans),
        .hsize        (hsize),
        .hwrite       (hwrite),
        .haddr        (haddr),
        .hwdata       (hwdata),
        .hready_out   (hready_out),
        .hresp        (hresp),
        .hrdata       (hrdata),
        .sram_wen     (sram_wen),
        .sram_ByteEna (sram_ByteEna),
        .sram_Addr    (sram_Addr),
        .sram_Wdata   (sram_Wdata),
        .sram_Rdata   (sram_Rdata)
    );

    // Single slave on the bus: the bus ready is this slave's ready.
    assign hready = hready_out;

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic logic [31:0] pattern(input logic [31:0] i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous SRAM model: byte-masked write, registered read.
    logic [31:0] mem [NWORDS];
    always @(posedge hclk) begin
        if (mem_init) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= pattern(32'(i));
        end else if (!sram_wen) begin
            for (int b = 0; b < 4; b++)
                if (!sram_ByteEna[b]) mem[sram_Addr][8*b +: 8] <= sram_Wdata[8*b +: 8];
        end else if (sram_ByteEna != 4'hF) begin
            sram_Rdata <= mem[sram_Addr];
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0; hwdata = 32'h0;
    endtask

    task automatic add_xfer(input logic sel, input logic [1:0] tr, input logic wr,
                            input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = d;
        xq.push_back(x);
    endtask

    // Pipelined AHB master: plays xq, records every cycle and every completed data phase.
    // Starts and ends 1 time unit after a rising edge.
    task automatic run_stream();
        int ai, di, waits, guard, limit;
        ai = 0; di = -1; waits = 0; guard = 0;
        limit = 8 * xq.size() + 20;
        clog.delete(); obs_wait.delete(); obs_resp.delete(); obs_rdata.delete();
        while ((ai < xq.size() || di >= 0) && guard < limit) begin
            if (ai < xq.size()) begin
                hsel = xq[ai].sel; htrans = xq[ai].trans; hwrite = xq[ai].wr;
                hsize = xq[ai].size; haddr = xq[ai].addr;
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0;
            end
            hwdata = (di >= 0) ? xq[di].wdata : 32'h0;
            @(negedge hclk);
            clog.push_back(cyc_t'{hready_out, hresp, hrdata, sram_wen, sram_ByteEna,
                                  sram_Addr, sram_Wdata});
            if (hready_out) begin
                if (di >= 0) begin
                    obs_wait.push_back(waits);
                    obs_resp.push_back(hresp);
                    obs_rdata.push_back(hrdata);
                end
                di = (ai < xq.size()) ? ai : -1;
                if (ai < xq.size()) ai++;
                waits = 0;
            end else begin
                waits++;
            end
            @(posedge hclk); #1;
            guard++;
        end
        n_cmp++;
        if (guard >= limit) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d cycles without completion, want under %0d",
                     guard, limit);
        end
        bus_idle();
    endtask

    task automatic test_reset();
        hresetn = 1'b0; mem_init = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        haddr = 32'h0000_1234; hwdata = 32'hFFFF_FFFF;
        @(posedge hclk); #1; mem_init = 1'b0;
        @(negedge hclk);
        n_cmp++;
        if ({hready_out, hresp} !== 3'b100) begin
            n_fail++; $display("FAIL reset_resp: got rdy=%b resp=%b want rdy=1 resp=00",
                               hready_out, hresp);
        end
        n_cmp++;
        if (hrdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_hrdata: got %h want 0", hrdata);
        end
        n_cmp++;
        if ({sram_wen, sram_ByteEna} !== 5'b1_1111) begin
            n_fail++; $display("FAIL reset_sram_idle: got wen=%b be=%b want 1/1111",
                               sram_wen, sram_ByteEna);
        end
        n_cmp++;
        if (sram_Addr !== '0 || sram_Wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_sram_bus: got addr=%h wdata=%h want 0/0",
                               sram_Addr, sram_Wdata);
        end
        hwrite = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        n_cmp++;
        if ({sram_wen, sram_ByteEna} !== 5'b1_1111) begin
            n_fail++; $display("FAIL reset_no_write: got wen=%b be=%b want 1/1111",
                               sram_wen, sram_ByteEna);
        end
        @(posedge hclk); #1;
        bus_idle();
        hresetn = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_word_write_read();
        xq.delete();
        add_xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        add_xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
        run_stream();
        n_cmp++;
        if (clog.size() != 4) begin
            n_fail++; $display("FAIL wr_rd_cycles: got %0d want 4", clog.size());
        end
        n_cmp++;
        if ({clog[1].wen, clog[1].be, clog[1].sa, clog[1].wd}
            !== {1'b0, 4'b0000, 14'h040, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL wr_rd_write: got wen=%b be=%b addr=%h wd=%h want 0/0000/040/deadbeef",
                               clog[1].wen, clog[1].be, clog[1].sa, clog[1].wd);
        end
        n_cmp++;
        if ({clog[2].wen, clog[2].be, clog[2].sa} !== {1'b1, 4'b0000, 14'h040}) begin
            n_fail++; $display("FAIL wr_rd_read_issue: got wen=%b be=%b addr=%h want 1/0000/040",
                               clog[2].wen, clog[2].be, clog[2].sa);
        end
        n_cmp++;
        if (obs_wait[0] != 1 || obs_wait[1] != 0) begin
            n_fail++; $display("FAIL wr_rd_waits: got %0d,%0d want 1,0", obs_wait[0], obs_wait[1]);
        end
        n_cmp++;
        if (obs_rdata[1] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_rd_data: got %h want deadbeef", obs_rdata[1]);
        end
    endtask

    task automatic test_byte_writes();
        logic [3:0]    exp_be [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0]    bv     [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0]    bes[$];
        logic [AW-1:0] adr[$];
        xq.delete();
        for (int i = 0; i < 4; i++)
            add_xfer(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 3'd0, 32'h200 + 32'(i), {4{bv[i]}});
        add_xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h200, 32'h0);
        run_stream();
        foreach (clog[i]) if (!clog[i].wen) begin
            bes.push_back(clog[i].be);
            adr.push_back(clog[i].sa);
        end
        n_cmp++;
        if (bes.size() != 4) begin
            n_fail++; $display("FAIL byte_write_count: got %0d want 4", bes.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bes[i] !== exp_be[i] || adr[i] !== 14'h080) begin
                n_fail++; $display("FAIL byte_write_%0d: got be=%b addr=%h want be=%b addr=080",
                                   i, bes[i], adr[i], exp_be[i]);
            end
        end
        n_cmp++;
        if (obs_rdata[4] !== 32'h4433_2211) begin
            n_fail++; $display("FAIL byte_readback: got %h want 44332211", obs_rdata[4]);
        end
    endtask

    task automatic test_half_bank();
        xq.delete();
        add_xfer(1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_8002, {2{16'hABCD}});
        add_xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_8000, 32'h0);
        run_stream();
        n_cmp++;
        if ({clog[1].wen, clog[1].be, clog[1].sa} !== {1'b0, 4'b0011, 14'h2000}) begin
            n_fail++; $display("FAIL half_write: got wen=%b be=%b addr=%h want 0/0011/2000",
                               clog[1].wen, clog[1].be, clog[1].sa);
        end
        n_cmp++;
        if (obs_rdata[1][31:16] !== 16'hABCD) begin
            n_fail++; $display("FAIL half_readback: got %h want abcd", obs_rdata[1][31:16]);
        end
    endtask

    task automatic test_error();
        int nwr;
        xq.delete();
        add_xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0101, 32'h0BAD_F00D);  // misaligned word
        add_xfer(1'b1, 2'b10, 1'b0, 3'd3, 32'h0000_0100, 32'h0);          // oversized
        add_xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
        run_stream();
        n_cmp++;
        if ({clog[1].rdy, clog[1].resp, clog[2].rdy, clog[2].resp} !== 6'b001_101) begin
            n_fail++; $display("FAIL err_two_cycle: got %b%b %b%b want 001 101",
                               clog[1].rdy, clog[1].resp, clog[2].rdy, clog[2].resp);
        end
        n_cmp++;
        if ({clog[3].rdy, clog[3].resp, clog[4].rdy, clog[4].resp} !== 6'b001_101) begin
            n_fail++; $display("FAIL err_size_resp: got %b%b %b%b want 001 101",
                               clog[3].rdy, clog[3].resp, clog[4].rdy, clog[4].resp);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (clog[i].be !== 4'b1111) begin
                n_fail++; $display("FAIL err_no_access_%0d: got be=%b want 1111", i, clog[i].be);
            end
        end
        nwr = 0;
        foreach (clog[i]) if (!clog[i].wen) nwr++;
        n_cmp++;
        if (nwr != 0 || obs_rdata[2] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL err_mem_intact: got writes=%0d data=%h want 0/deadbeef",
                               nwr, obs_rdata[2]);
        end
        n_cmp++;
        if (obs_resp[2] !== 2'b00 || obs_wait[0] != 1) begin
            n_fail++; $display("FAIL err_then_okay: got resp=%b wait=%0d want 00/1",
                               obs_resp[2], obs_wait[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        xq.delete();
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            add_xfer(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'h300 + 32'(4 * i), wd[i]);
        end
        for (int i = 0; i < 4; i++)
            add_xfer(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h300 + 32'(4 * i), 32'h0);
        run_stream();
        n_cmp++;
        if (clog.size() != 10) begin
            n_fail++; $display("FAIL b2b_cycles: got %0d want 10", clog.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs_wait[i] != ((i == 3) ? 1 : 0)) begin
                n_fail++; $display("FAIL b2b_wait_%0d: got %0d want %0d", i, obs_wait[i],
                                   (i == 3) ? 1 : 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs_rdata[4 + i] !== wd[i]) begin
                n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, obs_rdata[4 + i], wd[i]);
            end
        end
    endtask

    task automatic test_reset_during_write();
        xq.delete();
        add_xfer(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0400, 32'h5555_AAAA);
        run_stream();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0000_0400;
        @(posedge hclk); #1;
        bus_idle();
        hwdata = 32'h1234_5678;
        n_cmp++;
        if (sram_wen !== 1'b0) begin
            n_fail++; $display("FAIL rstwr_in_wr_data: got wen=%b want 0", sram_wen);
        end
        #1 hresetn = 1'b0;
        @(negedge hclk);
        n_cmp++;
        if ({sram_wen, sram_ByteEna} !== 5'b1_1111) begin
            n_fail++; $display("FAIL rstwr_aborted: got wen=%b be=%b want 1/1111",
                               sram_wen, sram_ByteEna);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        hwdata = 32'h0;
        @(posedge hclk); #1;
        xq.delete();
        add_xfer(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0400, 32'h0);
        run_stream();
        n_cmp++;
        if (obs_rdata[0] !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL rstwr_prior_data: got %h want 5555aaaa", obs_rdata[0]);
        end
    endtask

    function automatic bit is_acc(input xfer_t x);
        return x.sel && (x.trans == 2'b10 || x.trans == 2'b11);
    endfunction

    function automatic bit is_err(input xfer_t x);
        logic [31:0] nb;
        nb = 32'd1 << x.size;
        return is_acc(x) && (x.size > 3'd2 || (x.addr % nb) != 0);
    endfunction

    task automatic test_random();
        logic [31:0] ref_mem [RSPAN];
        xfer_t       x;
        xfer_t       y;
        int unsigned k, nb, lane, off;
        int          exp_wait, exp_wr, got_wr;
        logic [31:0] exp_rd;
        bit          vwr, vrd, nxt_rd;
        for (int i = 0; i < RSPAN; i++) ref_mem[i] = pattern(RBASE + 32'(i));
        for (int batch = 0; batch < 3; batch++) begin
            xq.delete();
            for (int n = 0; n < 100; n++) begin
                x.sel   = ($urandom_range(0, 19) != 0);
                x.trans = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1))
                                                      : 2'($urandom_range(2, 3));
                x.wr    = 1'($urandom_range(0, 1));
                x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                      : 3'($urandom_range(0, 2));
                nb      = (x.size <= 3'd2) ? (1 << x.size) : 1;
                lane    = ($urandom_range(0, 9) < 7) ? ($urandom_range(0, 3) / nb) * nb
                                                     : $urandom_range(0, 3);
                k       = $urandom_range(0, RSPAN - 1);
                x.addr  = (32'($urandom_range(0, 65535)) << 16) + ((RBASE + k) << 2) + lane;
                x.wdata = $urandom;
                xq.push_back(x);
            end
            run_stream();
            n_cmp++;
            if (obs_wait.size() != xq.size()) begin
                n_fail++; $display("FAIL rand_count_%0d: got %0d data phases want %0d",
                                   batch, obs_wait.size(), xq.size());
            end
            exp_wr = 0;
            for (int i = 0; i < xq.size(); i++) begin
                x = xq[i];
                vwr = is_acc(x) && !is_err(x) && x.wr;
                vrd = is_acc(x) && !is_err(x) && !x.wr;
                nxt_rd = 1'b0;
                if (i + 1 < xq.size()) begin
                    y = xq[i + 1];
                    nxt_rd = is_acc(y) && !is_err(y) && !y.wr;
                end
                exp_wait = is_err(x) ? 1 : ((vwr && nxt_rd) ? 1 : 0);
                k = ((x.addr / 4) % NWORDS) - RBASE;
                exp_rd = vrd ? ref_mem[k] : 32'h0;
                if (vwr) begin
                    exp_wr++;
                    off = x.addr % 4;
                    for (int b = off; b < off + (1 << x.size); b++)
                        ref_mem[k][8*b +: 8] = x.wdata[8*b +: 8];
                end
                n_cmp++;
                if (obs_wait[i] != exp_wait) begin
                    n_fail++; $display("FAIL rand_wait b%0d t%0d: got %0d want %0d",
                                       batch, i, obs_wait[i], exp_wait);
                end
                n_cmp++;
                if (obs_resp[i] !== (is_err(x) ? 2'b01 : 2'b00)) begin
                    n_fail++; $display("FAIL rand_resp b%0d t%0d: got %b want %b", batch, i,
                                       obs_resp[i], is_err(x) ? 2'b01 : 2'b00);
                end
                n_cmp++;
                if (obs_rdata[i] !== exp_rd) begin
                    n_fail++; $display("FAIL rand_rdata b%0d t%0d: got %h want %h",
                                       batch, i, obs_rdata[i], exp_rd);
                end
            end
            got_wr = 0;
            foreach (clog[i]) if (!clog[i].wen) got_wr++;
            n_cmp++;
            if (got_wr != exp_wr) begin
                n_fail++; $display("FAIL rand_write_cycles_%0d: got %0d want %0d",
                                   batch, got_wr, exp_wr);
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        hresetn  = 1'b0;
        mem_init = 1'b0;
        bus_idle();
        test_reset();
        test_word_write_read();
        test_byte_writes();
        test_half_bank();
        test_error();
        test_back_to_back();
        test_reset_during_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
